// File: rtl/qq_sort_ctrl_pkg.sv
// Shared types and constants for the QuickQ sorted-insertion controller.
package qq_pkg;

  localparam int QQ_MIN = 0;
  localparam int QQ_MAX = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WALK = 2'd2,
    INS  = 2'd3
  } qq_state_e;

endpackage

// File: rtl/qq_sort_ctrl_if.sv
// Request/response handshake plus external RAM port of the QuickQ controller.
interface qq_sort_ctrl_if #(
  parameter int W = 8,
  parameter int D = 4
) ();
  localparam int AW = $clog2(D);

  logic          enq_i;
  logic          deq_i;
  logic [W-1:0]  key_i;
  logic [W-1:0]  ram_out;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          we;
  logic [W-1:0]  wr_data;
  logic          rdy;
  logic          deq_o;
  logic [W-1:0]  key_o;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          err;

  modport slave (
    input  enq_i, deq_i, key_i, ram_out,
    output rd_addr, wr_addr, we, wr_data, rdy, deq_o, key_o, full, empty, count, err
  );

  modport master (
    output enq_i, deq_i, key_i, ram_out,
    input  rd_addr, wr_addr, we, wr_data, rdy, deq_o, key_o, full, empty, count, err
  );

endinterface

// File: rtl/qq_sort_ctrl_prio_cmp.sv
// Priority comparator: ge = 1 when key a has priority >= key b.
module qq_prio_cmp
  import qq_pkg::*;
#(
  parameter int W    = 8,
  parameter int MODE = QQ_MIN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ge
);

  assign ge = (MODE == QQ_MAX) ? (a >= b) : (a <= b);

endmodule

// File: rtl/qq_sort_ctrl.sv
// Sorted-insertion priority queue controller driving an external sync RAM.
// RAM[0..count-1] is kept sorted with the head at RAM[count-1].
module qq_sort_ctrl
  import qq_pkg::*;
#(
  parameter int W    = 8,
  parameter int D    = 4,
  parameter int MODE = QQ_MIN
) (
  input  logic          clk,
  input  logic          rst,
  qq_sort_ctrl_if.slave bus
);

  localparam int          AW       = $clog2(D);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(D);

  qq_state_e     state;
  logic [AW-1:0] ptr;
  logic [W-1:0]  kreg;
  logic          rep;
  logic [AW:0]   count;
  logic [AW:0]   cnt_nxt;
  logic          full;
  logic          empty;
  logic          deq_o;
  logic [W-1:0]  key_o;
  logic          err;

  logic          rdy;
  logic          accept;
  logic          ram_ge;
  logic          idle_direct;
  logic          idle_err;
  logic          idle_walk;
  logic          idle_pop;
  logic [AW-1:0] head_addr;

  assign rdy       = (state == IDLE);
  assign accept    = rdy && (bus.enq_i || bus.deq_i);
  assign head_addr = count[AW-1:0] - 1'b1;

  // Exactly one of these fires per accepted request; a replace on an empty
  // queue degenerates to a direct write.
  assign idle_direct = accept && bus.enq_i && empty;
  assign idle_err    = accept && ((bus.enq_i && !bus.deq_i && full) ||
                                  (bus.deq_i && !bus.enq_i && empty));
  assign idle_walk   = accept && bus.enq_i && !bus.deq_i && !empty && !full;
  assign idle_pop    = accept && bus.deq_i && !empty;

  qq_prio_cmp #(.W(W), .MODE(MODE)) u_cmp (
    .a  (bus.ram_out),
    .b  (kreg),
    .ge (ram_ge)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.we      = 1'b0;
    bus.wr_data = '0;
    cnt_nxt     = count;
    case (state)
      IDLE: begin
        if (idle_direct) begin
          bus.we      = 1'b1;
          bus.wr_data = bus.key_i;
          cnt_nxt     = CNT_ONE;
        end else if (idle_walk || idle_pop) begin
          bus.rd_addr = head_addr;
        end
      end
      POP: begin
        if (!rep) begin
          cnt_nxt = count - CNT_ONE;
        end else if (count != CNT_ONE) begin
          bus.rd_addr = head_addr - 1'b1;
        end
      end
      WALK: begin
        // Stored keys with priority >= kreg move up one slot, so equal keys
        // already queued stay ahead of the new one.
        bus.we      = 1'b1;
        bus.wr_addr = ptr + 1'b1;
        if (ram_ge) begin
          bus.wr_data = bus.ram_out;
          if (ptr != '0) bus.rd_addr = ptr - 1'b1;
        end else begin
          bus.wr_data = kreg;
          if (!rep) cnt_nxt = count + CNT_ONE;
        end
      end
      INS: begin
        bus.we      = 1'b1;
        bus.wr_data = kreg;
        if (!rep) cnt_nxt = count + CNT_ONE;
      end
      default: ;
    endcase
  end

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      kreg  <= '0;
      rep   <= 1'b0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      deq_o <= 1'b0;
      key_o <= '0;
      err   <= 1'b0;
    end else begin
      count <= cnt_nxt;
      full  <= (cnt_nxt == CNT_FULL);
      empty <= (cnt_nxt == '0);
      deq_o <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            kreg <= bus.key_i;
            rep  <= bus.enq_i && bus.deq_i;
          end
          if (idle_err) err <= 1'b1;
          if (idle_walk) begin
            ptr   <= head_addr;
            state <= WALK;
          end
          if (idle_pop) state <= POP;
        end
        POP: begin
          key_o <= bus.ram_out;
          deq_o <= 1'b1;
          if (!rep) begin
            state <= IDLE;
          end else if (count == CNT_ONE) begin
            state <= INS;
          end else begin
            ptr   <= head_addr - 1'b1;
            state <= WALK;
          end
        end
        WALK: begin
          if (ram_ge) begin
            if (ptr == '0) state <= INS;
            else           ptr   <= ptr - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        INS:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdy   = rdy;
  assign bus.deq_o = deq_o;
  assign bus.key_o = key_o;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = count;
  assign bus.err   = err;

endmodule

// File: tb/tb_qq_sort_ctrl.sv
// Directed bench for qq_sort_ctrl: one min-queue and one max-queue instance
// share the request stimulus; sel picks which one is observed.
module tb_qq_sort_ctrl;
  import qq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enq = 1'b0;
  logic       deq = 1'b0;
  logic [7:0] key = '0;
  logic       sel = 1'b0;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  qq_sort_ctrl_if #(.W(8), .D(4)) if_min ();
  qq_sort_ctrl_if #(.W(8), .D(4)) if_max ();

  assign if_min.enq_i = enq;
  assign if_min.deq_i = deq;
  assign if_min.key_i = key;
  assign if_max.enq_i = enq;
  assign if_max.deq_i = deq;
  assign if_max.key_i = key;

  logic [7:0] ram_min [4];
  logic [7:0] ram_max [4];

  always @(posedge clk) begin
    if (if_min.we) ram_min[if_min.wr_addr] <= if_min.wr_data;
    if_min.ram_out <= ram_min[if_min.rd_addr];
    if (if_max.we) ram_max[if_max.wr_addr] <= if_max.wr_data;
    if_max.ram_out <= ram_max[if_max.rd_addr];
  end

  qq_sort_ctrl #(.W(8), .D(4), .MODE(QQ_MIN)) u_min (.clk(clk), .rst(rst), .bus(if_min));
  qq_sort_ctrl #(.W(8), .D(4), .MODE(QQ_MAX)) u_max (.clk(clk), .rst(rst), .bus(if_max));

  logic       o_rdy, o_we, o_deq, o_err, o_full, o_empty;
  logic [7:0] o_key;
  logic [2:0] o_count;

  always_comb begin
    o_rdy   = sel ? if_max.rdy   : if_min.rdy;
    o_we    = sel ? if_max.we    : if_min.we;
    o_deq   = sel ? if_max.deq_o : if_min.deq_o;
    o_err   = sel ? if_max.err   : if_min.err;
    o_full  = sel ? if_max.full  : if_min.full;
    o_empty = sel ? if_max.empty : if_min.empty;
    o_key   = sel ? if_max.key_o : if_min.key_o;
    o_count = sel ? if_max.count : if_min.count;
  end

  // Results of the last request: rdy-return cycle, err/deq_o activity, writes.
  int         r_lat, r_err, r_err1, r_deq, r_deq_cyc, r_we_any;
  logic       r_we0;
  logic [7:0] r_key;

  task automatic do_req(input logic e, input logic d, input logic [7:0] k);
    int n;
    r_lat = -1; r_err = 0; r_err1 = 0; r_deq = 0; r_deq_cyc = -1; r_we_any = 0; r_key = '0;
    @(negedge clk);
    enq = e; deq = d; key = k;
    n = 0;
    while (!o_rdy && n < 50) begin @(negedge clk); n++; end
    if (!o_rdy) begin
      total++; bad++;
      $display("FAIL req_rdy_wait: rdy=%0b want 1", o_rdy);
    end
    #1 r_we0 = o_we;
    @(posedge clk);
    #1 enq = 1'b0; deq = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_err) r_err++;
      if (c == 1) r_err1 = int'(o_err);
      if (o_we) r_we_any++;
      if (o_deq) begin r_deq++; r_key = o_key; r_deq_cyc = c; end
      if (o_rdy && r_lat < 0) r_lat = c;
      if (r_lat >= 0 && c >= 2) break;
    end
    if (r_lat < 0) begin
      total++; bad++;
      $display("FAIL req_timeout: rdy never returned, want within 20 cycles");
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++; if (o_rdy !== 1'b1)   begin bad++; $display("FAIL reset_rdy: got %0b want 1", o_rdy); end
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0b want 1", o_empty); end
    total++; if (o_full !== 1'b0)  begin bad++; $display("FAIL reset_full: got %0b want 0", o_full); end
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", o_count); end
    total++; if (o_err !== 1'b0 || o_deq !== 1'b0 || o_key !== 8'd0 || o_we !== 1'b0)
      begin bad++; $display("FAIL reset_outs: err=%0b deq=%0b key=%0d we=%0b want 0 0 0 0", o_err, o_deq, o_key, o_we); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_enq_deq();
    logic [7:0] ins [4];
    int         lat [4];
    logic [7:0] exp_k [4];
    ins   = '{8'd5, 8'd2, 8'd9, 8'd2};
    lat   = '{1, 2, 4, 3};
    exp_k = '{8'd2, 8'd2, 8'd5, 8'd9};
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 1'b0, ins[i]);
      total++; if (r_lat !== lat[i])
        begin bad++; $display("FAIL enq_lat[%0d]: got %0d want %0d", i, r_lat, lat[i]); end
    end
    total++; if (o_full !== 1'b1 || o_count !== 3'd4)
      begin bad++; $display("FAIL enq_full: full=%0b count=%0d want 1 4", o_full, o_count); end
    total++; if (ram_min[0] !== 8'd9 || ram_min[1] !== 8'd5 || ram_min[2] !== 8'd2 || ram_min[3] !== 8'd2)
      begin bad++; $display("FAIL enq_ram: got %0d %0d %0d %0d want 9 5 2 2", ram_min[0], ram_min[1], ram_min[2], ram_min[3]); end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 1'b1, 8'd0);
      total++; if (r_key !== exp_k[i] || r_deq !== 1 || r_deq_cyc !== 2 || r_lat !== 2)
        begin bad++; $display("FAIL deq[%0d]: key=%0d deqs=%0d cyc=%0d lat=%0d want %0d 1 2 2", i, r_key, r_deq, r_deq_cyc, r_lat, exp_k[i]); end
    end
    total++; if (o_empty !== 1'b1 || o_count !== 3'd0)
      begin bad++; $display("FAIL deq_empty: empty=%0b count=%0d want 1 0", o_empty, o_count); end
  endtask

  task automatic test_boundaries();
    logic [7:0] ins [4];
    logic [7:0] exp_k [4];
    ins   = '{8'd8, 8'd1, 8'd4, 8'd3};
    exp_k = '{8'd1, 8'd3, 8'd4, 8'd8};
    sel = 1'b0;
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, ins[i]);
    do_req(1'b1, 1'b0, 8'd7);
    total++; if (r_err1 !== 1 || r_err !== 1)
      begin bad++; $display("FAIL full_err: cycle1=%0d pulses=%0d want 1 1", r_err1, r_err); end
    total++; if (r_we0 !== 1'b0 || r_we_any !== 0 || r_lat !== 1 || o_count !== 3'd4)
      begin bad++; $display("FAIL full_noop: we0=%0b writes=%0d lat=%0d count=%0d want 0 0 1 4", r_we0, r_we_any, r_lat, o_count); end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 1'b1, 8'd0);
      total++; if (r_key !== exp_k[i])
        begin bad++; $display("FAIL full_deq[%0d]: key=%0d want %0d", i, r_key, exp_k[i]); end
    end
    do_req(1'b0, 1'b1, 8'd0);
    total++; if (r_err1 !== 1 || r_err !== 1 || r_deq !== 0 || o_count !== 3'd0)
      begin bad++; $display("FAIL empty_err: cycle1=%0d pulses=%0d deqs=%0d count=%0d want 1 1 0 0", r_err1, r_err, r_deq, o_count); end
  endtask

  task automatic test_replace();
    logic [7:0] exp_k [3];
    exp_k = '{8'd4, 8'd6, 8'd8};
    sel = 1'b0;
    do_req(1'b1, 1'b0, 8'd6);
    do_req(1'b1, 1'b0, 8'd3);
    do_req(1'b1, 1'b0, 8'd8);
    do_req(1'b1, 1'b1, 8'd4);
    total++; if (r_key !== 8'd3 || r_deq !== 1 || r_deq_cyc !== 2)
      begin bad++; $display("FAIL rep_pop: key=%0d deqs=%0d cyc=%0d want 3 1 2", r_key, r_deq, r_deq_cyc); end
    total++; if (r_lat !== 3 || o_count !== 3'd3)
      begin bad++; $display("FAIL rep_lat: lat=%0d count=%0d want 3 3", r_lat, o_count); end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 1'b1, 8'd0);
      total++; if (r_key !== exp_k[i])
        begin bad++; $display("FAIL rep_deq[%0d]: key=%0d want %0d", i, r_key, exp_k[i]); end
    end
    do_req(1'b1, 1'b1, 8'd1);
    total++; if (o_count !== 3'd1 || r_deq !== 0 || r_err !== 0 || r_lat !== 1)
      begin bad++; $display("FAIL rep_empty: count=%0d deqs=%0d errs=%0d lat=%0d want 1 0 0 1", o_count, r_deq, r_err, r_lat); end
    do_req(1'b1, 1'b1, 8'd5);
    total++; if (r_key !== 8'd1 || o_count !== 3'd1)
      begin bad++; $display("FAIL rep_one: key=%0d count=%0d want 1 1", r_key, o_count); end
    do_req(1'b0, 1'b1, 8'd0);
    total++; if (r_key !== 8'd5 || o_empty !== 1'b1)
      begin bad++; $display("FAIL rep_one_deq: key=%0d empty=%0b want 5 1", r_key, o_empty); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_req(1'b1, 1'b0, 8'd1);
    do_req(1'b1, 1'b0, 8'd2);
    do_req(1'b1, 1'b0, 8'd3);
    @(negedge clk);
    enq = 1'b1; key = 8'd0;
    @(posedge clk);
    #1 enq = 1'b0;
    @(negedge clk);
    total++; if (o_rdy !== 1'b0)
      begin bad++; $display("FAIL mid_busy: rdy=%0b want 0", o_rdy); end
    #1 rst = 1'b1;
    #1;
    total++; if (o_count !== 3'd0 || o_empty !== 1'b1 || o_rdy !== 1'b1 || o_full !== 1'b0)
      begin bad++; $display("FAIL mid_reset: count=%0d empty=%0b rdy=%0b full=%0b want 0 1 1 0", o_count, o_empty, o_rdy, o_full); end
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b1, 1'b0, 8'd7);
    do_req(1'b0, 1'b1, 8'd0);
    total++; if (r_key !== 8'd7 || r_deq !== 1 || o_empty !== 1'b1)
      begin bad++; $display("FAIL mid_after: key=%0d deqs=%0d empty=%0b want 7 1 1", r_key, r_deq, o_empty); end
  endtask

  task automatic test_max_mode();
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [3];
    exp_a = '{8'd9, 8'd5, 8'd2};
    exp_b = '{8'd5, 8'd2, 8'd1};
    pulse_reset();
    sel = 1'b1;
    do_req(1'b1, 1'b0, 8'd5);
    do_req(1'b1, 1'b0, 8'd2);
    total++; if (r_lat !== 3)
      begin bad++; $display("FAIL max_lat_low: lat=%0d want 3", r_lat); end
    do_req(1'b1, 1'b0, 8'd9);
    total++; if (r_lat !== 2)
      begin bad++; $display("FAIL max_lat_head: lat=%0d want 2", r_lat); end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 1'b1, 8'd0);
      total++; if (r_key !== exp_a[i])
        begin bad++; $display("FAIL max_deq_a[%0d]: key=%0d want %0d", i, r_key, exp_a[i]); end
    end
    do_req(1'b1, 1'b0, 8'd5);
    do_req(1'b1, 1'b0, 8'd2);
    do_req(1'b1, 1'b0, 8'd1);
    total++; if (r_lat !== 4)
      begin bad++; $display("FAIL max_lat_tail: lat=%0d want 4", r_lat); end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 1'b1, 8'd0);
      total++; if (r_key !== exp_b[i])
        begin bad++; $display("FAIL max_deq_b[%0d]: key=%0d want %0d", i, r_key, exp_b[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_enq_deq();
    test_boundaries();
    test_replace();
    test_reset_mid();
    test_max_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
